// File: rtl/hazard_if.sv
// Hazard controller bundle: pipeline-side signals in, control selects out.
// Handshake note: there is no valid/ready pair here. MemReqM acts as the
// request "valid" and MemReadyM as "ready". An access completes on a clock
// edge where both are high. MemReadyM without MemReqM carries no meaning.
interface hazard_if #(parameter int CNT_W = 16);
  logic [4:0]       Rs1D, Rs2D;
  logic [4:0]       Rs1E, Rs2E;
  logic [4:0]       RdE, RdM, RdW;
  logic             RegWriteM, RegWriteW;
  logic [1:0]       ResultSrcE;
  logic             PCSrcE;
  logic             MemReqM;
  logic             MemReadyM;
  logic [1:0]       ForwardA, ForwardB;
  logic             StallF, StallD, StallE, StallM;
  logic             FlushD, FlushE;
  logic             MemErr;
  logic [CNT_W-1:0] StallCnt, FlushCnt;
  logic             dbg_state;   // 1 while the wait FSM is in WAIT

  // Pipeline side: drives hazard sources, consumes selects and controls.
  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    output RegWriteM, RegWriteW, ResultSrcE, PCSrcE, MemReqM, MemReadyM,
    input  ForwardA, ForwardB, StallF, StallD, StallE, StallM,
    input  FlushD, FlushE, MemErr, StallCnt, FlushCnt, dbg_state
  );

  // Controller side.
  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    input  RegWriteM, RegWriteW, ResultSrcE, PCSrcE, MemReqM, MemReadyM,
    output ForwardA, ForwardB, StallF, StallD, StallE, StallM,
    output FlushD, FlushE, MemErr, StallCnt, FlushCnt, dbg_state
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Five-stage pipeline hazard controller.
// Handles RAW forwarding, load-use stalls, redirect flushes, and data-memory
// waits with a timeout. It also keeps saturating stall and flush counters.
module hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input logic     clk,
  input logic     rst,
  hazard_if.slave hz
);

  localparam int WCW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;

  typedef enum logic {S_RUN = 1'b0, S_WAIT = 1'b1} state_t;

  state_t           state, state_n;
  logic [WCW-1:0]   wait_cnt;
  logic             timeout_now;
  logic             mw;
  logic             lu;
  logic             redirect;
  logic             stall_f, stall_d, stall_e, stall_m;
  logic             flush_d, flush_e;
  logic [1:0]       fwd_a, fwd_b;
  logic             mem_err;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  // M has priority over W. x0 is never forwarded.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input logic wm, input logic [4:0] rdm,
                                         input logic ww, input logic [4:0] rdw);
    if (wm && (rdm != 5'd0) && (rdm == rs))      return 2'b10;
    else if (ww && (rdw != 5'd0) && (rdw == rs)) return 2'b01;
    else                                         return 2'b00;
  endfunction

  // Hazard detection. A memory wait masks redirect and load-use, so those
  // stay pending and are re-evaluated once the memory releases.
  always_comb begin
    timeout_now = (state == S_WAIT) &&
                  (wait_cnt == WCW'(MEM_TIMEOUT - 1)) && !hz.MemReadyM;
    mw          = hz.MemReqM && !hz.MemReadyM && !timeout_now;
    lu          = (hz.ResultSrcE == 2'b01) && (hz.RdE != 5'd0) &&
                  ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));
    redirect    = !rst && !mw && hz.PCSrcE;
  end

  // Wait FSM next-state logic.
  always_comb begin
    state_n = state;
    case (state)
      S_RUN:   if (mw) state_n = S_WAIT;
      S_WAIT:  if (hz.MemReadyM || timeout_now) state_n = S_RUN;
      default: state_n = S_RUN;
    endcase
  end

  // Stall, flush and forward outputs in priority order.
  // While reset is held, both D and E are flushed so that bubbles fill the pipe.
  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    stall_m = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    fwd_a   = 2'b00;
    fwd_b   = 2'b00;
    if (rst) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
    end else begin
      fwd_a = fwd_sel(hz.Rs1E, hz.RegWriteM, hz.RdM, hz.RegWriteW, hz.RdW);
      fwd_b = fwd_sel(hz.Rs2E, hz.RegWriteM, hz.RdM, hz.RegWriteW, hz.RdW);
      if (mw) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        stall_e = 1'b1;
        stall_m = 1'b1;
      end else if (hz.PCSrcE) begin
        flush_d = 1'b1;
        flush_e = 1'b1;
      end else if (lu) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        flush_e = 1'b1;
      end
    end
  end

  // State register and wait counter. The counter clears on entry to WAIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_RUN;
      wait_cnt <= '0;
    end else begin
      state <= state_n;
      if (state == S_RUN && state_n == S_WAIT)
        wait_cnt <= '0;
      else if (state == S_WAIT && state_n == S_WAIT)
        wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // Sticky timeout error and saturating event counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_err   <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (timeout_now)
        mem_err <= 1'b1;
      if (stall_f && (stall_cnt != {CNT_W{1'b1}}))
        stall_cnt <= stall_cnt + 1'b1;
      if (redirect && (flush_cnt != {CNT_W{1'b1}}))
        flush_cnt <= flush_cnt + 1'b1;
    end
  end

  assign hz.ForwardA  = fwd_a;
  assign hz.ForwardB  = fwd_b;
  assign hz.StallF    = stall_f;
  assign hz.StallD    = stall_d;
  assign hz.StallE    = stall_e;
  assign hz.StallM    = stall_m;
  assign hz.FlushD    = flush_d;
  assign hz.FlushE    = flush_e;
  assign hz.MemErr    = mem_err;
  assign hz.StallCnt  = stall_cnt;
  assign hz.FlushCnt  = flush_cnt;
  assign hz.dbg_state = (state == S_WAIT);

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios followed by randomized traffic,
// each checked against a behavioural reference model. The model tracks a
// miss as "stall cycles spent on the current access".
module tb_hazard_ctrl;
  localparam int T     = 4;
  localparam int CW    = 4;
  localparam int CMAX  = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst;

  hazard_if #(.CNT_W(CW)) hz ();

  hazard_ctrl #(.MEM_TIMEOUT(T), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz.slave)
  );

  // Clock and reset: inputs change on negedge, outputs are checked 2 ns later.
  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  // Reference model state.
  int age     = 0;
  bit memerr  = 0;
  int scnt    = 0;
  int fcnt    = 0;
  bit last_timeout;
  bit last_stall_f;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int fwd_exp(input logic [4:0] rs);
    if (rst) return 0;
    if (hz.RegWriteM && hz.RdM != 0 && hz.RdM == rs) return 2;
    if (hz.RegWriteW && hz.RdW != 0 && hz.RdW == rs) return 1;
    return 0;
  endfunction

  task automatic idle_inputs();
    hz.Rs1D = 0; hz.Rs2D = 0; hz.Rs1E = 0; hz.Rs2E = 0;
    hz.RdE = 0; hz.RdM = 0; hz.RdW = 0;
    hz.RegWriteM = 0; hz.RegWriteW = 0; hz.ResultSrcE = 0;
    hz.PCSrcE = 0; hz.MemReqM = 0; hz.MemReadyM = 0;
  endtask

  // Checks all outputs for the inputs currently applied. It then advances the
  // model across the next rising edge.
  task automatic cycle();
    bit s_mem, tmo, lu_raw, redir, lu, sf, fd, fe;
    #2;
    s_mem  = !rst && hz.MemReqM && !hz.MemReadyM && (age < T);
    tmo    = !rst && (age >= T) && !hz.MemReadyM;
    lu_raw = (hz.ResultSrcE == 2'b01) && (hz.RdE != 0) &&
             (hz.RdE == hz.Rs1D || hz.RdE == hz.Rs2D);
    redir  = !rst && !s_mem && hz.PCSrcE;
    lu     = !rst && !s_mem && !hz.PCSrcE && lu_raw;
    sf     = s_mem || lu;
    fd     = rst || redir;
    fe     = rst || redir || lu;
    check("ForwardA", 32'(hz.ForwardA), 32'(fwd_exp(hz.Rs1E)));
    check("ForwardB", 32'(hz.ForwardB), 32'(fwd_exp(hz.Rs2E)));
    check("StallF",   32'(hz.StallF), 32'(sf));
    check("StallD",   32'(hz.StallD), 32'(sf));
    check("StallE",   32'(hz.StallE), 32'(s_mem));
    check("StallM",   32'(hz.StallM), 32'(s_mem));
    check("FlushD",   32'(hz.FlushD), 32'(fd));
    check("FlushE",   32'(hz.FlushE), 32'(fe));
    check("MemErr",   32'(hz.MemErr), rst ? 32'd0 : 32'(memerr));
    check("StallCnt", 32'(hz.StallCnt), rst ? 32'd0 : 32'(scnt));
    check("FlushCnt", 32'(hz.FlushCnt), rst ? 32'd0 : 32'(fcnt));
    check("in_wait",  32'(hz.dbg_state), 32'(!rst && age > 0));
    last_timeout = tmo;
    last_stall_f = sf;
    @(posedge clk);
    if (rst) begin
      age = 0; memerr = 0; scnt = 0; fcnt = 0;
    end else begin
      if (sf && scnt < CMAX) scnt++;
      if (redir && fcnt < CMAX) fcnt++;
      if (tmo) begin
        memerr = 1; age = 0;
      end else if (s_mem) age++;
      else if (hz.MemReadyM) age = 0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    cycle();
    @(negedge clk);
    rst = 1'b0;
  endtask

  int  n;
  bit  active;
  int  lat;

  initial begin
    rst = 1'b1;
    idle_inputs();
    cycle();
    check("rst_flushd", 32'(hz.FlushD), 32'd1);

    // RAW forwarding: M before W, x0 never forwarded.
    @(negedge clk); rst = 1'b0;
    hz.RdM = 5; hz.RdW = 5; hz.RegWriteM = 1; hz.RegWriteW = 1; hz.Rs1E = 5;
    cycle(); check("fwd_m", 32'(hz.ForwardA), 32'd2);
    @(negedge clk); hz.RegWriteM = 0;
    cycle(); check("fwd_w", 32'(hz.ForwardA), 32'd1);
    @(negedge clk); hz.RegWriteM = 1; hz.RdM = 0; hz.RdW = 0; hz.Rs1E = 0;
    cycle(); check("fwd_x0", 32'(hz.ForwardA), 32'd0);

    // Load-use for one cycle; the bubble then clears it.
    do_reset();
    hz.ResultSrcE = 2'b01; hz.RdE = 7; hz.Rs2D = 7;
    cycle(); check("lu_stall", 32'({hz.StallF, hz.StallD, hz.FlushE}), 32'h7);
    @(negedge clk); idle_inputs();
    cycle(); check("lu_cnt", 32'(hz.StallCnt), 32'd1);
    @(negedge clk); hz.ResultSrcE = 2'b01; hz.RdE = 0; hz.Rs2D = 0;
    cycle(); check("lu_x0", 32'(hz.StallF), 32'd0);

    // Redirect overrides load-use.
    do_reset();
    hz.ResultSrcE = 2'b01; hz.RdE = 7; hz.Rs1D = 7; hz.PCSrcE = 1;
    cycle(); check("br_lu", 32'({hz.FlushD, hz.FlushE, hz.StallF}), 32'h6);
    @(negedge clk); idle_inputs();
    cycle(); check("br_cnt", 32'(hz.FlushCnt), 32'd1);

    // Miss of 3 cycles with a redirect pending throughout.
    do_reset();
    n = 0;
    for (int i = 0; i < 4; i++) begin
      hz.MemReqM = 1; hz.MemReadyM = (i == 3); hz.PCSrcE = (i >= 1);
      cycle();
      if (hz.StallF && hz.StallD && hz.StallE && hz.StallM) n++;
      if (i < 3) check("miss_noflush", 32'(hz.FlushD), 32'd0);
      else       check("miss_relflush", 32'(hz.FlushD), 32'd1);
      @(negedge clk);
    end
    check("miss_stalls", 32'(n), 32'd3);
    idle_inputs();
    cycle(); check("miss_cnt", 32'(hz.StallCnt), 32'd3);
    check("miss_run", 32'(hz.dbg_state), 32'd0);

    // Timeout: the memory never answers.
    do_reset();
    n = 0;
    for (int i = 0; i < T + 1; i++) begin
      hz.MemReqM = 1; hz.MemReadyM = 0;
      cycle();
      if (hz.StallF) n++;
      @(negedge clk);
    end
    check("tmo_stalls", 32'(n), 32'(T));
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      cycle(); check("tmo_err", 32'(hz.MemErr), 32'd1);
      @(negedge clk);
    end

    // Reset in the middle of a wait.
    do_reset();
    check("err_clr", 32'(hz.MemErr), 32'd0);
    for (int i = 0; i < 2; i++) begin
      hz.MemReqM = 1; hz.MemReadyM = 0;
      cycle();
      @(negedge clk);
    end
    rst = 1'b1;
    #1;
    check("rst_drop", 32'({hz.StallF, hz.StallM}), 32'd0);
    check("rst_cnt", 32'(hz.StallCnt), 32'd0);
    check("rst_fl", 32'({hz.FlushD, hz.FlushE}), 32'h3);
    cycle();
    @(negedge clk); rst = 1'b0; idle_inputs();

    // Randomized traffic.
    active = 0; lat = 0;
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 499) == 0);
      hz.Rs1D = 5'($urandom_range(0, 7)); hz.Rs2D = 5'($urandom_range(0, 7));
      hz.Rs1E = 5'($urandom_range(0, 7)); hz.Rs2E = 5'($urandom_range(0, 7));
      hz.RdE  = 5'($urandom_range(0, 7)); hz.RdM  = 5'($urandom_range(0, 7));
      hz.RdW  = 5'($urandom_range(0, 7));
      hz.RegWriteM = 1'($urandom_range(0, 1));
      hz.RegWriteW = 1'($urandom_range(0, 1));
      hz.ResultSrcE = 2'($urandom_range(0, 3));
      hz.PCSrcE = ($urandom_range(0, 5) == 0);
      if (!active && $urandom_range(0, 3) == 0) begin
        active = 1; lat = $urandom_range(0, 6);
      end
      hz.MemReqM   = active;
      hz.MemReadyM = active ? (lat == 0) : ($urandom_range(0, 7) == 0);
      cycle();
      if (active) begin
        if (rst || hz.MemReadyM || last_timeout) active = 0;
        else lat--;
      end
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the five-stage core. It drives the execute stage's ForwardA/ForwardB selects and Stall input, and the stall/flush controls of the F/D, D/E, E/M and M/W pipeline registers. It resolves RAW forwarding, load-use stalls, taken-branch/jump flushes and multi-cycle data-memory waits. A wait FSM with timeout, plus saturating stall/flush event counters, carry the sequential state.

## Interface
- MEM_TIMEOUT, 16: max wait cycles for MemReadyM before abort
- CNT_W, 16: width of the performance counters
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- Rs1D, Rs2D  in  5  source regs of the instruction in Decode
- Rs1E, Rs2E  in  5  source regs of the instruction in Execute
- RdE, RdM, RdW  in  5  dest regs in E/M/W
- RegWriteM, RegWriteW  in  1  dest write enables in M/W
- ResultSrcE  in  2  result select in E; 2'b01 = load data
- PCSrcE  in  1  taken branch/jump resolved in Execute
- MemReqM  in  1  M-stage instruction accesses data memory
- MemReadyM  in  1  data memory completes the access this cycle
- ForwardA, ForwardB  out  2  00 = RD1E/RD2E, 01 = ResultW, 10 = ALUoutM; 11 never driven
- StallF, StallD  out  1  hold PC and F/D register
- StallE  out  1  hold E/M register (execute Stall)
- StallM  out  1  hold M/W register
- FlushD, FlushE  out  1  bubble into F/D and D/E registers
- MemErr  out  1  sticky: memory access timed out
- StallCnt, FlushCnt  out  CNT_W  saturating event counters

## Operation
- Forwarding (combinational), for each of Rs1E and Rs2E:
  - Select 10 if RegWriteM, RdM != 0 and RdM == RsE.
  - Otherwise select 01 if RegWriteW, RdW != 0 and RdW == RsE.
  - Otherwise select 00.
  - M has priority over W. x0 is never forwarded.
- Load-use: lu = (ResultSrcE == 2'b01) & RdE != 0 & (RdE == Rs1D | RdE == Rs2D).
- Redirect: PCSrcE.
- Memory wait: mw = MemReqM & ~MemReadyM & ~timeout_now.
- FSM states are RUN and WAIT.
  - RUN -> WAIT when mw.
  - WAIT -> RUN when MemReadyM or timeout_now.
  - timeout_now = (state == WAIT) & (wait_cnt == MEM_TIMEOUT-1) & ~MemReadyM.
  - wait_cnt clears on entering WAIT and increments each WAIT cycle.
  - timeout_now sets MemErr. MemErr is cleared only by rst.
- Output priority, highest first:
  1. mw: StallF = StallD = StallE = StallM = 1, no flush. A pending PCSrcE or lu is held and re-evaluated after release.
  2. PCSrcE: FlushD = FlushE = 1, no stalls. Redirect overrides lu.
  3. lu: StallF = StallD = 1 and FlushE = 1 for exactly one cycle.
  4. Otherwise all stalls and flushes are 0.
- Counters:
  - StallCnt +1 on every cycle with StallF = 1.
  - FlushCnt +1 on every cycle with a PCSrcE flush.
  - Both saturate at 2^CNT_W-1.

## Timing
- While rst = 1: state = RUN, wait_cnt = 0, MemErr = 0, StallCnt = FlushCnt = 0, all stalls = 0, FlushD = FlushE = 1, ForwardA = ForwardB = 00.
- Forward, stall and flush outputs are combinational in the same cycle as their inputs. State and counters update on the rising edge of clk.
- Zero-wait hit (MemReqM & MemReadyM in RUN): no stall, FSM stays in RUN.
- A miss stalls the pipeline from the first cycle MemReqM is seen without ready. Release is combinational in the cycle MemReadyM rises; the pipeline advances on that edge.
- Total stall on a miss = N cycles, where N = cycles until MemReadyM, capped at MEM_TIMEOUT. The timeout cycle itself releases the stall.
- rst asserted mid-WAIT returns to RUN immediately (asynchronous) and drops stalls at once.
- MemReadyM high while MemReqM = 0 is ignored.

## Test plan
- RAW forwarding: RdM = RdW = 5, both RegWrite = 1, Rs1E = 5 -> ForwardA = 10. Clear RegWriteM -> ForwardA = 01. Set RdM = RdW = 0 with Rs1E = 0 -> ForwardA = 00.
- Load-use: ResultSrcE = 01, RdE = 7, Rs2D = 7 -> StallF = StallD = FlushE = 1 for one cycle, StallCnt = 1. Same with RdE = 0 -> no stall.
- Branch vs load-use: lu true and PCSrcE = 1 together -> FlushD = FlushE = 1, StallF = 0, FlushCnt = 1.
- Miss: MemReqM = 1, MemReadyM low for 3 cycles then high -> all four stalls high for exactly 3 cycles, StallCnt = 3, FSM back in RUN. Assert PCSrcE during the wait -> no flush until release.
- Timeout: MEM_TIMEOUT = 4, MemReqM = 1, MemReadyM stuck at 0 -> stall for 4 cycles, MemErr = 1 from the next edge, remains 1 until rst.
- Reset mid-WAIT: after 2 wait cycles assert rst -> stalls drop that cycle, counters and MemErr read 0, FlushD = FlushE = 1 while rst is high.
